// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and types for the execute-stage multiply/divide unit.
// The MULDIV_* select codes match the decoder's operation field.
package muldiv_unit_pkg;

    localparam logic [2:0] MULDIV_DO_MUL     = 3'd0;
    localparam logic [2:0] MULDIV_DO_MULU    = 3'd1;
    localparam logic [2:0] MULDIV_DO_DIV     = 3'd2;
    localparam logic [2:0] MULDIV_DO_DIVU    = 3'd3;
    localparam logic [2:0] MULDIV_SELECT_HI  = 3'd4;
    localparam logic [2:0] MULDIV_SELECT_LO  = 3'd5;
    localparam logic [2:0] MULDIV_NONE       = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        write_en;
    } mdu_result_t;

    function automatic logic is_arith_op(input logic [2:0] sel);
        return (sel == MULDIV_DO_MUL)  || (sel == MULDIV_DO_MULU) ||
               (sel == MULDIV_DO_DIV)  || (sel == MULDIV_DO_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] sel);
        return (sel == MULDIV_DO_MUL) || (sel == MULDIV_DO_MULU);
    endfunction

    function automatic logic [31:0] negate32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning HI/LO: results are computed at start, held in
// pending registers, and committed after a fixed busy window.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        move_to,
    input  logic [2:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       pending_hi_q, pending_hi_d;
    logic [31:0]       pending_lo_q, pending_lo_d;
    logic              pending_we_q, pending_we_d;

    mdu_result_t       result;

    logic [63:0]       prod_s;
    logic [63:0]       prod_u;
    logic [31:0]       abs_a;
    logic [31:0]       abs_b;
    logic [31:0]       quo_mag;
    logic [31:0]       rem_mag;
    logic [31:0]       quo_u;
    logic [31:0]       rem_u;
    logic              b_is_zero;

    // Signed division goes through magnitudes so that 0x80000000 / -1 wraps
    // to 0x80000000 instead of relying on signed-overflow behaviour.
    always_comb begin
        b_is_zero = (b == 32'd0);
        prod_u    = {32'd0, a} * {32'd0, b};
        prod_s    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        abs_a     = a[31] ? negate32(a) : a;
        abs_b     = b[31] ? negate32(b) : b;
        quo_mag   = b_is_zero ? 32'd0 : (abs_a / abs_b);
        rem_mag   = b_is_zero ? 32'd0 : (abs_a % abs_b);
        quo_u     = b_is_zero ? 32'd0 : (a / b);
        rem_u     = b_is_zero ? 32'd0 : (a % b);

        result.hi       = 32'd0;
        result.lo       = 32'd0;
        result.write_en = 1'b0;
        case (sel)
            MULDIV_DO_MUL: begin
                result.hi       = prod_s[63:32];
                result.lo       = prod_s[31:0];
                result.write_en = 1'b1;
            end
            MULDIV_DO_MULU: begin
                result.hi       = prod_u[63:32];
                result.lo       = prod_u[31:0];
                result.write_en = 1'b1;
            end
            MULDIV_DO_DIV: begin
                result.lo       = (a[31] ^ b[31]) ? negate32(quo_mag) : quo_mag;
                result.hi       = a[31] ? negate32(rem_mag) : rem_mag;
                result.write_en = !b_is_zero;
            end
            MULDIV_DO_DIVU: begin
                result.lo       = quo_u;
                result.hi       = rem_u;
                result.write_en = !b_is_zero;
            end
            default: begin
                result.write_en = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pending_hi_d = pending_hi_q;
        pending_lo_d = pending_lo_q;
        pending_we_d = pending_we_q;

        case (state_q)
            ST_IDLE: begin
                // start has priority over move_to; a start with a non-arith
                // select is treated as a bubble.
                if (start) begin
                    if (is_arith_op(sel)) begin
                        state_d      = ST_BUSY;
                        cnt_d        = is_mul_op(sel) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                        pending_hi_d = result.hi;
                        pending_lo_d = result.lo;
                        pending_we_d = result.write_en;
                    end
                end else if (move_to) begin
                    if (sel == MULDIV_SELECT_HI) begin
                        hi_d = a;
                    end else if (sel == MULDIV_SELECT_LO) begin
                        lo_d = a;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (pending_we_q) begin
                        hi_d = pending_hi_q;
                        lo_d = pending_lo_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            pending_hi_q <= 32'd0;
            pending_lo_q <= 32'd0;
            pending_we_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pending_hi_q <= pending_hi_d;
            pending_lo_q <= pending_lo_d;
            pending_we_q <= pending_we_d;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign out  = (sel == MULDIV_SELECT_HI) ? hi_q : lo_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a cycle-level
// arithmetic reference model built on 64-bit integer operators.
module tb_muldiv_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        move_to;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] out;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pvalid;
    int          m_rem;

    muldiv_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .move_to (move_to),
        .sel     (sel),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .out     (out),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic: plain 64-bit signed/unsigned operators.
    task automatic ref_op(input logic [2:0] s, input logic [31:0] av, input logic [31:0] bv);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, pu, qu, ru;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = {32'd0, av};
        ub = {32'd0, bv};
        m_pvalid = 1'b1;
        case (s)
            3'd0: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; end
            3'd1: begin pu = ua * ub; m_phi = pu[63:32]; m_plo = pu[31:0]; end
            3'd2: begin
                if (bv == 32'd0) m_pvalid = 1'b0;
                else begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
            end
            default: begin
                if (bv == 32'd0) m_pvalid = 1'b0;
                else begin qu = ua / ub; ru = ua % ub; m_plo = qu[31:0]; m_phi = ru[31:0]; end
            end
        endcase
    endtask

    // One clock cycle: drive inputs after the falling edge, check the state
    // left by the previous rising edge, then advance the model.
    task automatic step(input logic rst, input logic st, input logic mt,
                        input logic [2:0] s, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        reset = rst; start = st; move_to = mt; sel = s; a = av; b = bv;
        #1;
        check_val("busy", {31'd0, busy}, (m_rem > 0) ? 32'd1 : 32'd0);
        check_val("hi", hi, m_hi);
        check_val("lo", lo, m_lo);
        check_val("out", out, (s == 3'd4) ? m_hi : m_lo);

        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_rem = 0; m_pvalid = 1'b0;
            m_phi = 32'd0; m_plo = 32'd0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pvalid) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st) begin
            if (s <= 3'd3) begin
                ref_op(s, av, bv);
                m_rem = (s <= 3'd1) ? MUL_N : DIV_N;
                $display("op sel=%0d a=%08h b=%08h -> hi=%08h lo=%08h wr=%0b",
                         s, av, bv, m_phi, m_plo, m_pvalid);
            end
        end else if (mt) begin
            if (s == 3'd4) m_hi = av;
            else if (s == 3'd5) m_lo = av;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd5, 32'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; move_to = 1'b0; sel = 3'd7; a = 32'd0; b = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_pvalid = 1'b0; m_rem = 0;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 1'b0, 3'd7, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 3'd7, 32'd0, 32'd0);
        check_val("reset_out", out, 32'd0);
        check_val("reset_busy", {31'd0, busy}, 32'd0);

        // mult, with mflo observing the old LO throughout the busy window
        step(1'b0, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'd2);
        check_val("mult_start_busy", {31'd0, busy}, 32'd0);
        idle(MUL_N);
        check_val("mult_last_busy", {31'd0, busy}, 32'd1);
        check_val("mflo_old", out, 32'd0);
        idle(1);
        check_val("mult_hi", hi, 32'hFFFF_FFFF);
        check_val("mult_lo", lo, 32'hFFFF_FFFE);

        step(1'b0, 1'b1, 1'b0, 3'd1, 32'hFFFF_FFFF, 32'd2);
        idle(MUL_N + 1);
        check_val("multu_hi", hi, 32'd1);
        check_val("multu_lo", lo, 32'hFFFF_FFFE);

        step(1'b0, 1'b1, 1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_N + 1);
        check_val("div_lo", lo, 32'hFFFF_FFFD);
        check_val("div_hi", hi, 32'hFFFF_FFFF);

        step(1'b0, 1'b1, 1'b0, 3'd3, 32'd7, 32'd0);
        idle(DIV_N + 1);
        check_val("divu0_lo", lo, 32'hFFFF_FFFD);
        check_val("divu0_hi", hi, 32'hFFFF_FFFF);

        step(1'b0, 1'b0, 1'b1, 3'd4, 32'h1234, 32'd0);
        idle(1);
        check_val("mthi", hi, 32'h1234);

        // collisions while busy: second start and move_to both ignored
        step(1'b0, 1'b1, 1'b0, 3'd0, 32'd3, 32'd4);
        step(1'b0, 1'b1, 1'b0, 3'd0, 32'd100, 32'd100);
        step(1'b0, 1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
        idle(MUL_N - 2);
        check_val("collide_busy", {31'd0, busy}, 32'd1);
        idle(1);
        check_val("collide_lo", lo, 32'd12);
        check_val("collide_busy_end", {31'd0, busy}, 32'd0);

        // same-cycle start and move_to: start wins
        step(1'b0, 1'b1, 1'b1, 3'd1, 32'd5, 32'd6);
        idle(MUL_N + 1);
        check_val("start_wins_lo", lo, 32'd30);

        // reset in the third busy cycle of a divide
        step(1'b0, 1'b1, 1'b0, 3'd2, 32'd100, 32'd7);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 3'd7, 32'd0, 32'd0);
        idle(1);
        check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
        idle(DIV_N + 1);
        check_val("rst_no_commit_lo", lo, 32'd0);
        check_val("rst_no_commit_hi", hi, 32'd0);

        step(1'b0, 1'b1, 1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_N + 1);
        check_val("ovf_lo", lo, 32'h8000_0000);
        check_val("ovf_hi", hi, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_st, r_mt;
            logic [2:0]  r_sel;
            logic [31:0] r_a, r_b;
            r_rst = ($urandom_range(0, 299) == 0);
            r_st  = ($urandom_range(0, 5) == 0);
            r_mt  = ($urandom_range(0, 4) == 0);
            r_sel = 3'($urandom_range(0, 7));
            r_a   = $urandom;
            r_b   = $urandom;
            case ($urandom_range(0, 9))
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 9));
                3: r_a = -32'($urandom_range(0, 1000));
                default: ;
            endcase
            step(r_rst, r_st, r_mt, r_sel, r_a, r_b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
